// File: rtl/spi_s_main_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_s_main_pkg
// Description : Shared constants and types for the SPI subordinate peripheral:
//               register offsets, SPIMODE layout, STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_s_main_pkg;

    // Width of the register offset field inside the decoded window
    localparam int ADDRBITS = 5;

    // Register offsets (identical offsets are shared with the manager)
    localparam logic [ADDRBITS-1:0] OFF_STATUS  = 5'h00;
    localparam logic [ADDRBITS-1:0] OFF_SPIMODE = 5'h04;
    localparam logic [ADDRBITS-1:0] OFF_TXDATA  = 5'h08;
    localparam logic [ADDRBITS-1:0] OFF_RXDATA  = 5'h0C;
    localparam logic [ADDRBITS-1:0] OFF_RXCOUNT = 5'h10;

    // STATUS bit positions
    localparam int STAT_RXVALID = 0;
    localparam int STAT_RXFULL  = 1;
    localparam int STAT_TXEMPTY = 2;
    localparam int STAT_OVF     = 3;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spimode_t;

    // Expand 4 byte enables into a 32-bit data mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_s_main_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_s_main_if
// Description : Memory-mapped worker bus between the CPU (master) and the
//               SPI subordinate register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_s_main_if;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteEn;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_addr;
    logic [3:0]  rd_byteEn;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;

    modport master (
        output wr_addr, wr_data, wr_byteEn, wr_valid,
        output rd_addr, rd_byteEn, rd_valid,
        input  wr_ready, rd_ready, rd_data
    );

    modport slave (
        input  wr_addr, wr_data, wr_byteEn, wr_valid,
        input  rd_addr, rd_byteEn, rd_valid,
        output wr_ready, rd_ready, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_s_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_s_fifo
// Description : Synchronous FIFO with wrap-around pointers carrying an extra
//               MSB to tell full from empty. Push while full is dropped unless
//               a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_s_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer advance on accepted push/pop
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; head is read combinationally so a simultaneous
    // push/pop on a full FIFO still returns the old head
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/spi_s_main.sv
`default_nettype none
// ============================================================================
// Module      : spi_s_main
// Description : SPI subordinate. Synchronizes CS/SCK/DIN, shifts bytes
//               LSB-first, buffers received bytes in an RX FIFO and returns
//               the TXDATA holding register on DOUT. CPU access through a
//               simple memory-mapped worker bus.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_s_main
    import spi_s_main_pkg::*;
#(
    parameter logic [31:0] ADDR       = 32'h1000_0100,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic   clock,
    input  wire logic   reset,
    spi_s_main_if.slave bus,
    input  wire logic   CS,
    input  wire logic   SCK,
    input  wire logic   DIN,
    output logic        DOUT,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [1:0]  cs_sync, sck_sync, din_sync;
    logic        cs_prev, sck_prev;
    logic        cs_s, din_s, cs_fall, cs_rise, lead, trail;
    logic        sample_edge, shift_edge;
    spimode_t    mode;
    logic [7:0]  txdata;
    logic        tx_empty, ovf;
    logic [0:0]  state;
    logic [2:0]  bitcnt;
    logic [7:0]  rx;
    logic [8:0]  tx9;
    logic [7:0]  load_val;
    logic        start, byte_done, shifter_load;
    logic        wr_hit, wr_en0, wr_status, wr_mode, wr_tx;
    logic        rd_hit, rd_held, pop;
    logic [ADDRBITS-1:0] wr_off, rd_off;
    logic [31:0] rd_val;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, fifo_empty;
    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.wr_data[31:8], bus.wr_byteEn[3:1]};

    // Two-flop synchronizers plus one stage of history for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync  <= 2'b11;
            sck_sync <= 2'b00;
            din_sync <= 2'b00;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[0], CS};
            sck_sync <= {sck_sync[0], SCK};
            din_sync <= {din_sync[0], DIN};
            cs_prev  <= cs_sync[1];
            sck_prev <= sck_sync[1];
        end
    end

    assign cs_s    = cs_sync[1];
    assign din_s   = din_sync[1];
    assign cs_fall = cs_prev & ~cs_s;
    assign cs_rise = ~cs_prev & cs_s;
    // CPOL is applied to both samples, so a mode change never fakes an edge
    assign lead    =  (sck_sync[1] ^ mode.cpol) & ~(sck_prev ^ mode.cpol);
    assign trail   = ~(sck_sync[1] ^ mode.cpol) &  (sck_prev ^ mode.cpol);
    assign sample_edge = mode.cpha ? trail : lead;
    assign shift_edge  = mode.cpha ? lead  : trail;

    assign load_val     = tx_empty ? 8'h00 : txdata;
    assign start        = (state == ST_IDLE) && cs_fall;
    assign byte_done    = (state == ST_SHIFT) && !cs_rise && sample_edge && (bitcnt == 3'd7);
    assign shifter_load = start || byte_done;

    // Shifter FSM. tx9 is one bit wider than a byte so that DOUT is always
    // tx9[0]: CPHA=1 loads with a leading 0 so the first leading edge shifts
    // bit 0 out; a CPHA=0 reload duplicates bit 0 so the trailing edge that
    // follows the last sample keeps bit 0 on the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            bitcnt <= 3'd0;
            rx     <= 8'h00;
            tx9    <= 9'h000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state  <= ST_SHIFT;
                        bitcnt <= 3'd0;
                        tx9    <= mode.cpha ? {load_val, 1'b0} : {1'b0, load_val};
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state  <= ST_IDLE;
                        bitcnt <= 3'd0;
                        tx9    <= 9'h000;
                    end else if (sample_edge) begin
                        rx     <= {din_s, rx[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            tx9 <= mode.cpha ? {load_val, 1'b0} : {load_val, load_val[0]};
                    end else if (shift_edge) begin
                        tx9 <= {1'b0, tx9[8:1]};
                    end
                end
            endcase
        end
    end

    assign DOUT = (state == ST_SHIFT) & tx9[0];
    assign irq  = ~fifo_empty;

    spi_s_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (byte_done),
        .pop   (pop),
        .din   ({din_s, rx[7:1]}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write decode
    assign wr_hit    = bus.wr_valid && (bus.wr_addr[31:ADDRBITS] == ADDR[31:ADDRBITS]) && !bus.wr_ready;
    assign wr_off    = bus.wr_addr[ADDRBITS-1:0];
    assign wr_en0    = wr_hit && bus.wr_byteEn[0];
    assign wr_status = wr_en0 && (wr_off == OFF_STATUS);
    assign wr_mode   = wr_en0 && (wr_off == OFF_SPIMODE) && cs_s;
    assign wr_tx     = wr_en0 && (wr_off == OFF_TXDATA);

    // Read decode; a held rd_valid is one request, so it is re-armed only
    // after rd_valid drops
    assign rd_hit = bus.rd_valid && (bus.rd_addr[31:ADDRBITS] == ADDR[31:ADDRBITS])
                    && !bus.rd_ready && !rd_held;
    assign rd_off = bus.rd_addr[ADDRBITS-1:0];
    assign pop    = rd_hit && (rd_off == OFF_RXDATA) && !fifo_empty;

    // Register file; a TXDATA write wins over a same-cycle shifter load
    always_ff @(posedge clock) begin
        if (reset) begin
            mode         <= '0;
            txdata       <= 8'h00;
            tx_empty     <= 1'b1;
            ovf          <= 1'b0;
            bus.wr_ready <= 1'b0;
        end else begin
            bus.wr_ready <= wr_hit;
            if (wr_mode) mode   <= spimode_t'(bus.wr_data[1:0]);
            if (wr_tx)   txdata <= bus.wr_data[7:0];
            if (wr_tx)
                tx_empty <= 1'b0;
            else if (shifter_load)
                tx_empty <= 1'b1;
            if (byte_done && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr_status && bus.wr_data[STAT_OVF])
                ovf <= 1'b0;
        end
    end

    // Read data mux
    always_comb begin
        rd_val = 32'h0;
        case (rd_off)
            OFF_STATUS: begin
                rd_val[STAT_RXVALID] = ~fifo_empty;
                rd_val[STAT_RXFULL]  = fifo_full;
                rd_val[STAT_TXEMPTY] = tx_empty;
                rd_val[STAT_OVF]     = ovf;
            end
            OFF_SPIMODE: rd_val = {30'h0, mode.cpol, mode.cpha};
            OFF_TXDATA:  rd_val = {24'h0, txdata};
            OFF_RXDATA:  rd_val = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
            OFF_RXCOUNT: rd_val = {{(32-CW){1'b0}}, fifo_count};
            default:     rd_val = 32'h0;
        endcase
    end

    // Read response registers, one-cycle pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rd_ready <= 1'b0;
            bus.rd_data  <= 32'h0;
            rd_held      <= 1'b0;
        end else begin
            bus.rd_ready <= rd_hit;
            bus.rd_data  <= rd_hit ? (rd_val & byte_mask(bus.rd_byteEn)) : 32'h0;
            if (!bus.rd_valid)
                rd_held <= 1'b0;
            else if (rd_hit)
                rd_held <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_s_main.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_s_main
// Description : Self-checking bench for spi_s_main. An SPI manager model
//               drives the pins; a queue-based reference model predicts the
//               RX FIFO, STATUS flags and the bytes returned on DOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_s_main;
    import spi_s_main_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0100;
    localparam int          DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic CS    = 1'b1;
    logic SCK   = 1'b0;
    logic DIN   = 1'b0;
    logic DOUT;
    logic irq;

    spi_s_main_if bif();

    spi_s_main #(.ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif),
        .CS    (CS),
        .SCK   (SCK),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_txe = 1'b1;
    logic [7:0] exp_txd = 8'h00;
    logic [7:0] exp_miso [9];

    // Manager-side byte buffers
    logic [7:0] m_tx [8];
    logic [7:0] m_rx [8];
    bit         cur_cpol = 1'b0;
    bit         cur_cpha = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data, input logic [3:0] be);
        @(negedge clock);
        bif.wr_addr   = BASE + {27'h0, off};
        bif.wr_data   = data;
        bif.wr_byteEn = be;
        bif.wr_valid  = 1'b1;
        @(negedge clock);
        bif.wr_valid  = 1'b0;
        check("wr_ready", {31'h0, bif.wr_ready}, 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] off, input logic [3:0] be, output logic [31:0] data);
        @(negedge clock);
        bif.rd_addr   = BASE + {27'h0, off};
        bif.rd_byteEn = be;
        bif.rd_valid  = 1'b1;
        @(negedge clock);
        bif.rd_valid  = 1'b0;
        check("rd_ready", {31'h0, bif.rd_ready}, 32'd1);
        data = bif.rd_data;
    endtask

    task automatic read_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, 4'hF, d);
        check(tag, d, exp);
    endtask

    function automatic logic [31:0] exp_status();
        return {28'h0, exp_ovf, exp_txe, (exp_q.size() == DEPTH), (exp_q.size() != 0)};
    endfunction

    task automatic write_tx(input logic [7:0] b);
        bus_write(OFF_TXDATA, {24'h0, b}, 4'hF);
        exp_txd = b;
        exp_txe = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        bus_write(OFF_SPIMODE, {30'h0, m}, 4'hF);
        cur_cpol = m[1];
        cur_cpha = m[0];
        SCK = cur_cpol;
        repeat (4) @(negedge clock);
    endtask

    // Model of one CS frame: every load takes TXDATA if present, else 0,
    // and empties the holding register; each complete byte is pushed
    task automatic model_frame(input int nbytes, input int cut);
        int full_bytes;
        full_bytes = (cut == 0) ? nbytes : cut / 8;
        for (int b = 0; b <= full_bytes; b++) begin
            exp_miso[b] = exp_txe ? 8'h00 : exp_txd;
            exp_txe = 1'b1;
        end
        for (int b = 0; b < full_bytes; b++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(m_tx[b]);
            else exp_ovf = 1'b1;
        end
    endtask

    // SPI manager: LSB first, half period hp clocks, cut>0 aborts after cut bits
    task automatic spi_frame(input int nbytes, input int cut, input int hp);
        int  nb;
        bit  stop;
        nb   = 0;
        stop = 1'b0;
        SCK  = cur_cpol;
        DIN  = cur_cpha ? 1'b0 : m_tx[0][0];
        @(negedge clock);
        CS = 1'b0;
        repeat (hp) @(negedge clock);
        for (int b = 0; b < nbytes && !stop; b++) begin
            m_rx[b] = 8'h00;
            for (int i = 0; i < 8 && !stop; i++) begin
                if (!cur_cpha) begin
                    m_rx[b][i] = DOUT;
                    SCK = ~cur_cpol;
                    repeat (hp) @(negedge clock);
                    SCK = cur_cpol;
                    if (i < 7) DIN = m_tx[b][i+1];
                    else if (b + 1 < nbytes) DIN = m_tx[b+1][0];
                    repeat (hp) @(negedge clock);
                end else begin
                    SCK = ~cur_cpol;
                    DIN = m_tx[b][i];
                    repeat (hp) @(negedge clock);
                    m_rx[b][i] = DOUT;
                    SCK = cur_cpol;
                    repeat (hp) @(negedge clock);
                end
                nb++;
                if (cut != 0 && nb == cut) stop = 1'b1;
            end
        end
        CS  = 1'b1;
        DIN = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic drain();
        logic [7:0] e;
        int n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            read_check("rxdata_drain", OFF_RXDATA, {24'h0, e});
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int pulses;
        logic [31:0] held_data;
        logic [7:0]  first;

        bif.wr_addr = '0; bif.wr_data = '0; bif.wr_byteEn = '0; bif.wr_valid = 1'b0;
        bif.rd_addr = '0; bif.rd_byteEn = '0; bif.rd_valid = 1'b0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_dout", {31'h0, DOUT}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_wr_ready", {31'h0, bif.wr_ready}, 32'h0);
        check("rst_rd_ready", {31'h0, bif.rd_ready}, 32'h0);
        check("rst_rd_data", bif.rd_data, 32'h0);
        read_check("rst_status", OFF_STATUS, 32'h4);
        read_check("rst_rxcount", OFF_RXCOUNT, 32'h0);
        read_check("rst_spimode", OFF_SPIMODE, 32'h0);
        read_check("rst_txdata", OFF_TXDATA, 32'h0);

        // Mode 0 exchange 0x3C / 0xA5
        write_tx(8'hA5);
        read_check("status_txfull", OFF_STATUS, exp_status());
        m_tx[0] = 8'h3C;
        model_frame(1, 0);
        spi_frame(1, 0, 4);
        check("m0_miso", {24'h0, m_rx[0]}, {24'h0, exp_miso[0]});
        check("m0_irq_high", {31'h0, irq}, 32'h1);
        read_check("m0_status", OFF_STATUS, exp_status());
        drain();
        check("m0_irq_low", {31'h0, irq}, 32'h0);

        // Modes 1..3 with 0x81 / 0x7E
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1:0]);
            write_tx(8'h7E);
            m_tx[0] = 8'h81;
            model_frame(1, 0);
            spi_frame(1, 0, 5);
            check("mode_miso", {24'h0, m_rx[0]}, {24'h0, exp_miso[0]});
            read_check("mode_rxcount", OFF_RXCOUNT, exp_q.size());
            drain();
        end

        // Randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            int n, hp;
            set_mode(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) != 0) write_tx(8'($urandom));
            n  = $urandom_range(1, 3);
            hp = $urandom_range(4, 6);
            for (int b = 0; b < n; b++) m_tx[b] = 8'($urandom);
            model_frame(n, 0);
            spi_frame(n, 0, hp);
            for (int b = 0; b < n; b++)
                check("rand_miso", {24'h0, m_rx[b]}, {24'h0, exp_miso[b]});
            read_check("rand_status", OFF_STATUS, exp_status());
            drain();
        end

        // Overflow: 5 bytes into a 4-deep FIFO under one CS
        set_mode(2'b00);
        for (int b = 0; b < 5; b++) m_tx[b] = 8'h10 + 8'(b);
        model_frame(5, 0);
        spi_frame(5, 0, 4);
        read_check("ovf_rxcount", OFF_RXCOUNT, 32'd4);
        read_check("ovf_status", OFF_STATUS, exp_status());
        drain();
        bus_write(OFF_STATUS, 32'h8, 4'hF);
        exp_ovf = 1'b0;
        read_check("ovf_cleared", OFF_STATUS, exp_status());

        // Back-to-back pair with TX empty on the second byte
        write_tx(8'h5A);
        m_tx[0] = 8'hC3; m_tx[1] = 8'h96;
        model_frame(2, 0);
        spi_frame(2, 0, 4);
        check("b2b_miso0", {24'h0, m_rx[0]}, 32'h5A);
        check("b2b_miso1", {24'h0, m_rx[1]}, 32'h00);
        read_check("b2b_status", OFF_STATUS, exp_status());
        drain();

        // Abort after 4 bits, then a full byte
        write_tx(8'hF0);
        m_tx[0] = 8'hE7;
        model_frame(1, 4);
        spi_frame(1, 4, 4);
        read_check("abort_rxcount", OFF_RXCOUNT, 32'd0);
        check("abort_dout", {31'h0, DOUT}, 32'h0);
        m_tx[0] = 8'h6D;
        model_frame(1, 0);
        spi_frame(1, 0, 4);
        read_check("after_abort_rx", OFF_RXDATA, 32'h6D);
        void'(exp_q.pop_front());

        // SPIMODE write while CS is low is ignored
        CS = 1'b0;
        exp_txe = 1'b1;
        repeat (6) @(negedge clock);
        bus_write(OFF_SPIMODE, 32'h3, 4'hF);
        read_check("mode_locked", OFF_SPIMODE, 32'h0);
        CS = 1'b1;
        repeat (8) @(negedge clock);

        // Empty RXDATA read, byte enables, unmapped offset
        read_check("empty_rxdata", OFF_RXDATA, 32'h0);
        read_check("empty_rxcount", OFF_RXCOUNT, 32'h0);
        bus_read(OFF_STATUS, 4'h0, d);
        check("be_read_mask", d, 32'h0);
        write_tx(8'h42);
        bus_write(OFF_TXDATA, 32'h99, 4'b0010);
        read_check("be_write_mask", OFF_TXDATA, {24'h0, exp_txd});
        read_check("unmapped", 5'h14, 32'h0);

        // Held rd_valid pops once
        m_tx[0] = 8'hB1; m_tx[1] = 8'h2E;
        model_frame(2, 0);
        spi_frame(2, 0, 4);
        first = exp_q.pop_front();
        @(negedge clock);
        bif.rd_addr   = BASE + {27'h0, OFF_RXDATA};
        bif.rd_byteEn = 4'hF;
        bif.rd_valid  = 1'b1;
        pulses    = 0;
        held_data = 32'h0;
        repeat (3) begin
            @(negedge clock);
            if (bif.rd_ready) begin pulses++; held_data = bif.rd_data; end
        end
        bif.rd_valid = 1'b0;
        @(negedge clock);
        if (bif.rd_ready) pulses++;
        check("held_pulses", pulses, 32'd1);
        check("held_data", held_data, {24'h0, first});
        read_check("held_rxcount", OFF_RXCOUNT, exp_q.size());
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
